instr_fetch_buffer: RTL

- Fetch stage directly downstream of program_counter.
- Takes the current PC, issues in-order word reads to instruction memory, and holds returned instructions with their PCs in a small reservation queue.
- Presents {pc, instr} to decode with a valid/ready handshake.
- Drives fetch_hold so the PC only advances when a fetch is accepted.
- Supports pipeline flush, including discard of in-flight responses.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_slot_array.sv | 71 +++++++
 rtl/instr_fetch_buffer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch buffer: default widths,
// the NOP encoding used as the reset value for instruction storage,
// and the slot record layout at default widths.
package fetch_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 32;
    localparam int unsigned DEF_DATA_WIDTH = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0] pc;
        logic [DEF_DATA_WIDTH-1:0] instr;
        logic                      filled;
    } fetch_slot_t;

endpackage

// File: rtl/fetch_slot_array.sv
// DEPTH-entry slot storage for the fetch buffer. The PC is written when a
// request is reserved, the instruction when its response fills the slot.
// Reads are asynchronous. The per-slot filled bits are cleared by pop, by
// reserve and by a global clear (flush).
module fetch_slot_array
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         clear,
    input  logic                         reserve_en,
    input  logic [$clog2(DEPTH)-1:0]     reserve_idx,
    input  logic [ADDR_WIDTH-1:0]        reserve_pc,
    input  logic                         fill_en,
    input  logic [$clog2(DEPTH)-1:0]     fill_idx,
    input  logic [DATA_WIDTH-1:0]        fill_instr,
    input  logic                         pop_en,
    input  logic [$clog2(DEPTH)-1:0]     pop_idx,
    input  logic [$clog2(DEPTH)-1:0]     read_idx,
    output logic [ADDR_WIDTH-1:0]        read_pc,
    output logic [DATA_WIDTH-1:0]        read_instr,
    output logic                         read_filled
);

    logic [ADDR_WIDTH-1:0] pc_mem    [DEPTH];
    logic [DATA_WIDTH-1:0] instr_mem [DEPTH];
    logic [DEPTH-1:0]      filled;

    // Slot payload and filled-bit updates.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= DATA_WIDTH'(NOP_INSTR);
            end
            filled <= '0;
        end else begin
            if (reserve_en) begin
                pc_mem[reserve_idx] <= reserve_pc;
            end
            if (fill_en) begin
                instr_mem[fill_idx] <= fill_instr;
            end
            if (clear) begin
                filled <= '0;
            end else begin
                if (pop_en) begin
                    filled[pop_idx] <= 1'b0;
                end
                if (reserve_en) begin
                    filled[reserve_idx] <= 1'b0;
                end
                if (fill_en) begin
                    filled[fill_idx] <= 1'b1;
                end
            end
        end
    end

    // Asynchronous read of the head slot.
    always_comb begin
        read_pc     = pc_mem[read_idx];
        read_instr  = instr_mem[read_idx];
        read_filled = filled[read_idx];
    end

endmodule

// File: rtl/instr_fetch_buffer.sv
// Fetch stage: issues in-order word reads at the current PC, queues the
// returned instructions with their PCs and presents them to decode with a
// valid/ready handshake. fetch_hold stalls the PC unless a request is
// accepted. Flush discards queued entries and drops in-flight responses.
// Optional performance counters are enabled with the FETCH_PERF_EN macro.
module instr_fetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] pc,
    output logic                  fetch_hold,
    input  logic                  flush,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_resp_valid,
    input  logic [DATA_WIDTH-1:0] imem_resp_data,
    output logic                  if_valid,
    output logic [ADDR_WIDTH-1:0] if_pc,
    output logic [DATA_WIDTH-1:0] if_instr,
    input  logic                  id_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]           perf_bubble_cnt,
    output logic [15:0]           perf_flush_cnt
`endif
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned PW = IW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] ONE_P   = PW'(1);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] fill_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] discard_cnt;

    logic [PW-1:0] occupancy;
    logic [PW-1:0] in_flight;
    logic [PW-1:0] pending_drop;
    logic [PW-1:0] flush_discard;
    logic          fire;
    logic          resp_take;
    logic          pop;
    logic          out_valid;

    logic [ADDR_WIDTH-1:0] slot_pc;
    logic [DATA_WIDTH-1:0] slot_instr;
    logic                  slot_filled;
    logic [ADDR_WIDTH-1:0] hold_pc;
    logic [DATA_WIDTH-1:0] hold_instr;

    // Request, response-accept, pop and flush-discard decisions.
    always_comb begin
        occupancy      = wr_ptr - rd_ptr;
        in_flight      = wr_ptr - fill_ptr;
        imem_req_valid = reset_n && !flush && (occupancy < DEPTH_P) && (discard_cnt == '0);
        fire           = imem_req_valid && imem_req_ready;
        fetch_hold     = !fire;
        imem_addr      = pc;
        resp_take      = imem_resp_valid && !flush && (discard_cnt == '0) && (fill_ptr != wr_ptr);
        out_valid      = (rd_ptr != fill_ptr) && slot_filled && !flush;
        pop            = out_valid && id_ready;
        // Drops still owed from an earlier flush are carried forward so a
        // second flush during discard cannot lose track of stale responses.
        pending_drop   = discard_cnt + in_flight;
        if (imem_resp_valid && (pending_drop != '0)) begin
            flush_discard = pending_drop - ONE_P;
        end else begin
            flush_discard = pending_drop;
        end
    end

    // Queue pointers and stale-response discard counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            fill_ptr    <= '0;
            rd_ptr      <= '0;
            discard_cnt <= '0;
        end else if (flush) begin
            wr_ptr      <= '0;
            fill_ptr    <= '0;
            rd_ptr      <= '0;
            discard_cnt <= flush_discard;
        end else begin
            if (fire) begin
                wr_ptr <= wr_ptr + ONE_P;
            end
            if (resp_take) begin
                fill_ptr <= fill_ptr + ONE_P;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ONE_P;
            end
            if (imem_resp_valid && (discard_cnt != '0)) begin
                discard_cnt <= discard_cnt - ONE_P;
            end
        end
    end

    fetch_slot_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_slots (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (flush),
        .reserve_en  (fire),
        .reserve_idx (wr_ptr[IW-1:0]),
        .reserve_pc  (pc),
        .fill_en     (resp_take),
        .fill_idx    (fill_ptr[IW-1:0]),
        .fill_instr  (imem_resp_data),
        .pop_en      (pop),
        .pop_idx     (rd_ptr[IW-1:0]),
        .read_idx    (rd_ptr[IW-1:0]),
        .read_pc     (slot_pc),
        .read_instr  (slot_instr),
        .read_filled (slot_filled)
    );

    // Remember the last presented entry so outputs hold while empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_pc    <= '0;
            hold_instr <= DATA_WIDTH'(NOP_INSTR);
        end else if (out_valid) begin
            hold_pc    <= slot_pc;
            hold_instr <= slot_instr;
        end
    end

    // Decode-facing outputs: live head slot when valid, else held values.
    always_comb begin
        if_valid = out_valid;
        if (out_valid) begin
            if_pc    = slot_pc;
            if_instr = slot_instr;
        end else begin
            if_pc    = hold_pc;
            if_instr = hold_instr;
        end
    end

`ifdef FETCH_PERF_EN
    // Saturating counters for decode bubbles and flush cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_bubble_cnt <= '0;
            perf_flush_cnt  <= '0;
        end else begin
            if (id_ready && !out_valid && !flush && (perf_bubble_cnt != '1)) begin
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
            end
            if (flush && (perf_flush_cnt != '1)) begin
                perf_flush_cnt <= perf_flush_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
